// File: rtl/byte_serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// byte_serial_adder_pkg
// Shared definitions for the byte-serial adder and its testbench:
//   - BYTE_W  : width of one operand byte (the per-cycle datapath width)
//   - state_t : FSM state encodings (IDLE, ADD, DONE)
// ---------------------------------------------------------------------------
package byte_serial_adder_pkg;

    // Width of the slice added each cycle.
    localparam int BYTE_W = 8;

    // Controller states.
    // IDLE waits for start.
    // ADD walks the bytes, least significant first.
    // DONE is the single cycle after the last byte.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/byte_serial_adder_eight_bit_adder.sv
// ---------------------------------------------------------------------------
// eight_bit_adder
// Purely combinational 8-bit adder with carry in/out. This is the per-byte
// datapath of byte_serial_adder.
// Ports:
//   a     [7:0] in  : first addend byte
//   b     [7:0] in  : second addend byte
//   c           in  : carry-in
//   sum   [7:0] out : (a + b + c) mod 256
//   carry       out : carry-out of the byte addition
// ---------------------------------------------------------------------------
module eight_bit_adder
    import byte_serial_adder_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              c,
    output logic [BYTE_W-1:0] sum,
    output logic              carry
);

    // Widen by one bit so the carry-out falls out of the top of the sum.
    logic [BYTE_W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, c};
        sum      = full_sum[BYTE_W-1:0];
        carry    = full_sum[BYTE_W];
    end

endmodule

// File: rtl/byte_serial_adder.sv
// ---------------------------------------------------------------------------
// byte_serial_adder
// Adds two NBYTES-byte operands one byte per clock, using a single 8-bit
// adder. Operands and carry-in are latched when start is accepted, so the
// inputs may change freely while the addition is in progress.
//
// Timing, for start sampled at edge N:
//   - busy is high after edges N .. N+NBYTES-1.
//   - The final result and cout are complete after edge N+NBYTES.
//   - done pulses for one cycle after edge N+NBYTES+1.
//
// Ports:
//   clk                   in  : clock, rising edge
//   rst_n                 in  : asynchronous active-low reset
//   start                 in  : add request, only looked at in IDLE
//   op_a   [8*NBYTES-1:0] in  : first operand
//   op_b   [8*NBYTES-1:0] in  : second operand
//   cin                   in  : carry into byte 0
//   busy                  out : high while bytes are being added
//   done                  out : one-cycle completion pulse
//   result [8*NBYTES-1:0] out : registered sum (mod 2^(8*NBYTES))
//   cout                  out : registered carry out of the top byte
// ---------------------------------------------------------------------------
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [BYTE_W*NBYTES-1:0] op_a,
    input  logic [BYTE_W*NBYTES-1:0] op_b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [BYTE_W*NBYTES-1:0] result,
    output logic                     cout
);

    localparam int OP_W  = BYTE_W * NBYTES;
    // Keep the index at least one bit wide so NBYTES=1 still elaborates.
    localparam int IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

    state_t            state;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   b_reg;
    logic              carry_reg;
    logic [IDX_W-1:0]  idx;

    logic [BYTE_W-1:0] a_byte;
    logic [BYTE_W-1:0] b_byte;
    logic [BYTE_W-1:0] byte_sum;
    logic              byte_carry;

    // Select the current byte of each latched operand for the shared adder.
    always_comb begin
        a_byte = a_reg[BYTE_W*int'(idx) +: BYTE_W];
        b_byte = b_reg[BYTE_W*int'(idx) +: BYTE_W];
    end

    eight_bit_adder u_eight_bit_adder (
        .a     (a_byte),
        .b     (b_byte),
        .c     (carry_reg),
        .sum   (byte_sum),
        .carry (byte_carry)
    );

    // Controller plus datapath registers.
    // busy is raised on the accepting edge and dropped on the edge that leaves ADD.
    // done is raised on the edge that leaves DONE, so it lands in the first IDLE cycle.
    // A start held high in that cycle is accepted on the next edge. That same edge
    // clears done, so busy and done are never high at the same time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            idx       <= '0;
            result    <= '0;
            cout      <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_reg     <= op_a;
                        b_reg     <= op_b;
                        carry_reg <= cin;
                        idx       <= '0;
                        result    <= '0;
                        cout      <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ADD;
                    end
                end
                ADD: begin
                    result[BYTE_W*int'(idx) +: BYTE_W] <= byte_sum;
                    carry_reg <= byte_carry;
                    idx       <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        cout  <= byte_carry;
                        busy  <= 1'b0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_byte_serial_adder.sv
// ---------------------------------------------------------------------------
// tb_byte_serial_adder
// Directed, table-driven bench for byte_serial_adder with NBYTES = 4, plus
// hand-written sequences for the multi-cycle corner cases.
// ---------------------------------------------------------------------------
module tb_byte_serial_adder;
    import byte_serial_adder_pkg::*;

    localparam int NBYTES = 4;
    localparam int OP_W   = BYTE_W * NBYTES;
    localparam int PERIOD = NBYTES + 2;

    logic            clk;
    logic            rst_n;
    logic            start;
    logic [OP_W-1:0] op_a;
    logic [OP_W-1:0] op_b;
    logic            cin;
    logic            busy;
    logic            done;
    logic [OP_W-1:0] result;
    logic            cout;

    int total;
    int bad;

    typedef struct {
        logic [OP_W-1:0] a;
        logic [OP_W-1:0] b;
        logic            c;
        logic [OP_W-1:0] exp_result;
        logic            exp_cout;
    } vec_t;

    vec_t vecs[8];

    byte_serial_adder #(.NBYTES(NBYTES)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op_a   (op_a),
        .op_b   (op_b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .result (result),
        .cout   (cout)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Core comparison: counts every check and reports any difference.
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance one clock and sample 1 unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for exactly one edge, then scramble the
    // inputs. The scrambled values show whether the operands were latched.
    task automatic applyStimulus(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic c);
        start = 1'b1;
        op_a  = a;
        op_b  = b;
        cin   = c;
        step();
        start = 1'b0;
        op_a  = ~a;
        op_b  = OP_W'($urandom);
        cin   = ~c;
        check("accept_busy", 64'(busy), 64'd1);
        check("accept_result_cleared", 64'(result), 64'd0);
    endtask

    // Wait (bounded) for done. Check latency, outputs, that busy never
    // overlapped done, and that done is a single-cycle pulse.
    task automatic checkOutput(input string name, input logic [OP_W-1:0] exp_r, input logic exp_c);
        int cycles;
        int overlap;
        cycles  = 0;
        overlap = 0;
        while (!done && cycles < 20) begin
            step();
            cycles++;
            if (busy && done) overlap++;
        end
        check({name, "_latency"}, 64'(cycles), 64'(NBYTES + 1));
        check({name, "_result"}, 64'(result), 64'(exp_r));
        check({name, "_cout"}, 64'(cout), 64'(exp_c));
        check({name, "_busy_done_overlap"}, 64'(overlap), 64'd0);
        step();
        check({name, "_done_one_cycle"}, 64'(done), 64'd0);
        check({name, "_result_held"}, 64'(result), 64'(exp_r));
    endtask

    initial begin
        int done_count;

        total = 0;
        bad   = 0;
        start = 1'b0;
        op_a  = '0;
        op_b  = '0;
        cin   = 1'b0;
        rst_n = 1'b0;

        vecs[0] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0};
        vecs[5] = '{32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 32'h0000_0000, 1'b1};
        vecs[6] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0};
        vecs[7] = '{32'h0102_0304, 32'h1020_3040, 1'b1, 32'h1122_3345, 1'b0};

        // Reset state
        #3;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", 64'(result), 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Table-driven directed vectors
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_result, vecs[i].exp_cout);
        end

        // A second start during ADD is ignored: one done and the first sum.
        applyStimulus(32'h0000_0010, 32'h0000_0016, 1'b0);
        step();
        start = 1'b1;
        op_a  = 32'h0F0F_0F0F;
        op_b  = 32'h0101_0101;
        step();
        start = 1'b0;
        done_count = 0;
        for (int k = 0; k < PERIOD + 4; k++) begin
            if (done) done_count++;
            step();
        end
        check("ignore_start_done_count", 64'(done_count), 64'd1);
        check("ignore_start_result", 64'(result), 64'h26);
        check("ignore_start_cout", 64'(cout), 64'd0);

        // Reset mid-ADD at idx=2 clears outputs at once and suppresses done.
        applyStimulus(32'h1111_1111, 32'h2222_2222, 1'b0);
        step();
        step();
        check("pre_abort_partial", 64'(result), 64'h0000_3333);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_result", 64'(result), 64'd0);
        check("abort_cout", 64'(cout), 64'd0);
        step();
        @(negedge clk);
        rst_n = 1'b1;
        done_count = 0;
        for (int k = 0; k < PERIOD + 2; k++) begin
            step();
            if (done) done_count++;
        end
        check("abort_no_done", 64'(done_count), 64'd0);
        applyStimulus(32'h0000_002B, 32'h0000_005B, 1'b1);
        checkOutput("post_reset", 32'h0000_0087, 1'b0);

        // start held high: back-to-back operations every NBYTES+2 cycles.
        // k counts cycles after the first accepting edge.
        start = 1'b1;
        op_a  = 32'h0101_0101;
        op_b  = 32'h0202_0202;
        cin   = 1'b0;
        for (int k = 0; k < 3 * PERIOD; k++) begin
            step();
            check($sformatf("held_busy_k%0d", k), 64'(busy), 64'((k % PERIOD) < NBYTES));
            check($sformatf("held_done_k%0d", k), 64'(done), 64'((k % PERIOD) == NBYTES + 1));
            if ((k % PERIOD) == 0)
                check($sformatf("held_cleared_k%0d", k), 64'(result), 64'd0);
            if ((k % PERIOD) == NBYTES + 1)
                check($sformatf("held_result_k%0d", k), 64'(result), 64'h0303_0303);
        end
        start = 1'b0;
        for (int k = 0; k < PERIOD + 2; k++) step();
        check("final_idle_busy", 64'(busy), 64'd0);
        check("final_result_held", 64'(result), 64'h0303_0303);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/byte_serial_adder.md
BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

Interface
REQ-001 SHALL have parameter NBYTES, default 4, giving the number of operand bytes (operand width = 8*NBYTES).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request to add the presented operands; sampled only in IDLE.
REQ-005 SHALL have port op_a, input, 8*NBYTES bits: first operand.
REQ-006 SHALL have port op_b, input, 8*NBYTES bits: second operand.
REQ-007 SHALL have port cin, input, 1 bit: carry-in into byte 0.
REQ-008 SHALL have port busy, output, 1 bit: high while bytes are being added.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when result and cout are complete.
REQ-010 SHALL have port result, output, 8*NBYTES bits: registered sum.
REQ-011 SHALL have port cout, output, 1 bit: registered carry-out of the most significant byte.

Function
REQ-012 SHALL implement FSM states IDLE, ADD and DONE, with IDLE as the reset state.
REQ-013 In IDLE with start=1, SHALL latch op_a, op_b and cin, load the carry register with cin, clear the byte index to 0, clear result and cout to 0, and go to ADD.
REQ-014 In IDLE with start=0, SHALL hold all registers.
REQ-015 In ADD, each cycle SHALL add byte[idx] of both latched operands plus the carry register, write the sum to result[8*idx +: 8], store the carry-out in the carry register, and increment idx.
REQ-016 In ADD at idx = NBYTES-1, SHALL also write the final carry to cout and go to DONE.
REQ-017 In DONE, SHALL assert done for exactly one cycle, then return to IDLE.
REQ-018 SHALL make busy=1 exactly while in ADD; busy and done SHALL never be high together.
REQ-019 Latency: with start sampled at edge N, SHALL present done=1 and final result/cout after edge N+NBYTES+1.
REQ-020 SHALL ignore start in ADD and DONE; no queuing. A start held high through DONE is accepted at the first IDLE edge.
REQ-021 SHALL use the latched operands, so input changes after acceptance have no effect on the result.
REQ-022 SHALL hold result and cout stable from DONE until the next accepted start.
REQ-023 Width rules: idx SHALL be wide enough for NBYTES-1, and arithmetic SHALL be modulo 2^(8*NBYTES), with overflow reported only on cout.

Reset
REQ-024 On rst_n=0, SHALL immediately (asynchronously) force state=IDLE, busy=0, done=0, result=0, cout=0, idx=0, carry register=0, and latched operands=0.
REQ-025 On reset during ADD or DONE, SHALL abort the operation with no done pulse; the first start after rst_n deasserts SHALL be accepted normally.

Structure
REQ-026 SHALL instantiate exactly one 8-bit combinational adder sub-module, eight_bit_adder (8-bit A, 8-bit B, carry-in C; outputs 8-bit sum and carry), as its per-byte datapath.
REQ-027 SHALL define the FSM state encodings (IDLE, ADD, DONE) and the byte width constant (8) in a shared package/header used by this block and its bench.

Verification
REQ-028 SHALL pass this directed test: op_a=0x12345678, op_b=0x11111111, cin=0, start pulse -> done after 5 cycles with result=0x23456789, cout=0.
REQ-029 SHALL pass this directed test: op_a=0xFFFFFFFF, op_b=0x00000001, cin=0 -> result=0x00000000, cout=1 (carry ripples through all 4 bytes).
REQ-030 SHALL pass this directed test: op_a=0xFFFFFFFF, op_b=0x00000000, cin=1 -> result=0x00000000, cout=1; and 0x80000000+0x80000000, cin=0 -> result=0x00000000, cout=1.
REQ-031 SHALL pass this directed test: start with 0x00000010+0x00000016, then a second start with different operands on cycle 2 of ADD -> second start ignored; result=0x00000026, cout=0; exactly one done pulse.
REQ-032 SHALL pass this directed test: rst_n low for one cycle during ADD (idx=2) -> all outputs 0 immediately, no done; the next start of 0x0000002B+0x0000005B with cin=1 -> result=0x00000087, cout=0.
REQ-033 SHALL pass this directed test: start held high continuously -> operations repeat every NBYTES+2 cycles, busy/done timing matches REQ-019, and result changes only at acceptance (cleared) and during ADD.
